// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin arbitration between the core LSU (port 0) and the
// debug loader (port 1), single-port DMEM access with byte/half lane handling and RMW stores.
module dmem_ctrl #(
    parameter int unsigned REG_WIDTH       = 32,
    parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [1:0]                     req,
    input  logic [1:0]                     we,
    input  logic [3:0]                     size,
    input  logic [1:0]                     uns,
    input  logic [2*DMEM_ADDR_WIDTH-1:0]   addr,
    input  logic [2*REG_WIDTH-1:0]         wdata,
    output logic [1:0]                     ready,
    output logic [1:0]                     rsp_valid,
    output logic                           rsp_err,
    output logic [REG_WIDTH-1:0]           rsp_rdata,
    output logic                           dm_wr_en,
    output logic [DMEM_ADDR_WIDTH-1:0]     dm_addr,
    output logic [REG_WIDTH-1:0]           dm_wr_data,
    input  logic [REG_WIDTH-1:0]           dm_rd_data
);
    localparam int unsigned AW = DMEM_ADDR_WIDTH;
    localparam int unsigned DW = REG_WIDTH;

    typedef enum logic [2:0] {IDLE, READ, WRITE, RMW_RD, RMW_WR} state_t;

    state_t          state;
    logic            last_grant;
    logic            l_port;
    logic [1:0]      l_size;
    logic            l_uns;
    logic [1:0]      l_lane;
    logic [15:0]     l_wdata;

    logic [1:0]      grant;
    logic            sel;
    logic            s_we;
    logic [1:0]      s_size;
    logic            s_uns;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic            s_misaligned;
    logic [DW-1:0]   load_val;
    logic [DW-1:0]   merged;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;

    // Round-robin grant, only offered while idle
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            if (req == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
            else              grant = req;
        end
    end

    assign ready   = grant;
    assign sel     = grant[1];
    assign s_we    = sel ? we[1]              : we[0];
    assign s_size  = sel ? size[3:2]          : size[1:0];
    assign s_uns   = sel ? uns[1]             : uns[0];
    assign s_addr  = sel ? addr[2*AW-1:AW]    : addr[AW-1:0];
    assign s_wdata = sel ? wdata[2*DW-1:DW]   : wdata[DW-1:0];
    assign s_misaligned = (s_size == 2'b01 && s_addr[0]) || (s_size[1] && s_addr[1:0] != 2'b00);

    // Load lane extraction/extension and store-lane merge for the latched request
    always_comb begin
        rd_byte  = dm_rd_data[{l_lane, 3'b000} +: 8];
        rd_half  = dm_rd_data[{l_lane[1], 4'b0000} +: 16];
        load_val = dm_rd_data;
        if (l_size == 2'b00)
            load_val = l_uns ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        else if (l_size == 2'b01)
            load_val = l_uns ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
        merged = dm_rd_data;
        if (l_size[0]) merged[{l_lane[1], 4'b0000} +: 16] = l_wdata;
        else           merged[{l_lane, 3'b000} +: 8]      = l_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            l_port     <= 1'b0;
            l_size     <= 2'b00;
            l_uns      <= 1'b0;
            l_lane     <= 2'b00;
            l_wdata    <= 16'h0;
            rsp_valid  <= 2'b00;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            dm_wr_en   <= 1'b0;
            dm_addr    <= '0;
            dm_wr_data <= '0;
        end else begin
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            dm_wr_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        last_grant <= sel;
                        l_port     <= sel;
                        l_size     <= s_size;
                        l_uns      <= s_uns;
                        l_lane     <= s_addr[1:0];
                        l_wdata    <= s_wdata[15:0];
                        if (s_misaligned) begin
                            // Error response straight from IDLE, DMEM untouched
                            rsp_valid <= sel ? 2'b10 : 2'b01;
                            rsp_err   <= 1'b1;
                        end else begin
                            dm_addr <= {s_addr[AW-1:2], 2'b00};
                            if (!s_we) begin
                                state <= READ;
                            end else if (s_size[1]) begin
                                state      <= WRITE;
                                dm_wr_en   <= 1'b1;
                                dm_wr_data <= s_wdata;
                            end else begin
                                state <= RMW_RD;
                            end
                        end
                    end
                end
                READ: begin
                    rsp_valid <= l_port ? 2'b10 : 2'b01;
                    rsp_rdata <= load_val;
                    state     <= IDLE;
                end
                WRITE: begin
                    rsp_valid <= l_port ? 2'b10 : 2'b01;
                    state     <= IDLE;
                end
                RMW_RD: begin
                    dm_wr_data <= merged;
                    dm_wr_en   <= 1'b1;
                    state      <= RMW_WR;
                end
                RMW_WR: begin
                    rsp_valid <= l_port ? 2'b10 : 2'b01;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, 32, data word width (fixed at 32 for lane logic).
REQ-002 SHALL have parameter DMEM_ADDR_WIDTH, 10, byte address width (AW).
REQ-003 SHALL have the following ports; requester n (n=0 core LSU, n=1 debug loader) occupies slice n of every packed vector:
- clk  in  1  single clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  2  request valid per requester.
- we  in  2  1 = store, 0 = load.
- size  in  4  2 bits per requester: 00 byte, 01 half, 10 word, 11 reserved and treated as word.
- uns  in  2  load zero-extend when 1, sign-extend when 0.
- addr  in  2*AW  byte address.
- wdata  in  64  store data, LSB-justified.
- ready  out  2  accept strobe; the request is accepted when req[n] && ready[n].
- rsp_valid  out  2  one-cycle response pulse.
- rsp_err  out  1  misalignment error, qualified by rsp_valid.
- rsp_rdata  out  32  load result, qualified by rsp_valid; 0 for stores and errors.
- dm_wr_en  out  1  DMEM write enable.
- dm_addr  out  AW  DMEM word-aligned byte address.
- dm_wr_data  out  32  DMEM write data.
- dm_rd_data  in  32  DMEM read data, valid from the negedge of the cycle dm_addr is driven with dm_wr_en=0.

Function
REQ-004 SHALL implement the FSM states IDLE, READ, WRITE, RMW_RD and RMW_WR.
REQ-005 SHALL assert ready only in IDLE, to at most one requester, and combinationally from req.
REQ-006 SHALL arbitrate round-robin: if both requesters request, grant the one not granted last; if one requests, grant it; after reset, port 0 wins the first contention.
REQ-007 SHALL, on accept, latch port id, we, size, uns, addr and wdata, and ignore the inputs until the next IDLE.
REQ-008 SHALL treat a request as misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-009 SHALL complete a misaligned request without any DMEM access: stay in IDLE; in the next cycle pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
REQ-010 SHALL, for an aligned request accepted in IDLE at cycle T, go to the next state at T+1 as follows: load -> READ; word store -> WRITE; byte/half store -> RMW_RD.
REQ-011 SHALL drive dm_addr = {latched addr[AW-1:2], 2'b00} in every non-IDLE state.
REQ-012 SHALL drive dm_wr_en=1 only in WRITE and RMW_WR; dm_wr_en SHALL be 0 in IDLE, READ and RMW_RD.
REQ-013 SHALL, in READ, register dm_rd_data at the posedge ending the state.
REQ-014 SHALL select the load lane as byte addr[1:0]*8 or half addr[1]*16, extend it per uns, and return it with rsp_valid at T+2.
REQ-015 SHALL, in WRITE, drive dm_wr_data = wdata and pulse rsp_valid at T+2.
REQ-016 SHALL, in RMW_RD, register dm_rd_data.
REQ-017 SHALL, in RMW_RD -> RMW_WR, replace only the addressed byte/half with wdata[7:0]/[15:0] and write the merged word, then pulse rsp_valid at T+3.
REQ-018 SHALL return to IDLE in the cycle rsp_valid is high, so a new accept can occur in that cycle, giving back-to-back throughput.
REQ-019 SHALL keep rsp_err=0 for aligned requests.
REQ-020 SHALL assert rsp_valid only on the latched port id bit.
REQ-021 SHALL hold dm_addr and dm_wr_data at their last values in IDLE.

Reset
REQ-022 SHALL, while reset_n=0, force state=IDLE, round-robin pointer to "port 1 last granted", rsp_valid=0, rsp_err=0, rsp_rdata=0, dm_wr_en=0, dm_addr=0 and dm_wr_data=0.
REQ-023 SHALL, on reset asserted mid-operation, abort the operation: no response and no further DMEM write; any RMW merge not yet written is lost.

Verification
REQ-024 SHALL pass: port0 word store 0xDEADBEEF @0x010, then port0 word load @0x010 -> dm_wr_en one cycle; load rsp_rdata=0xDEADBEEF with rsp_valid[0] two cycles after accept.
REQ-025 SHALL pass: word 0x11223344 @0x020, then byte store 0xAA @0x021 -> RMW sequence of 3 cycles; word load @0x020 returns 0x1122AA44.
REQ-026 SHALL pass: word 0x0000F080 @0x030, then half load @0x030 with uns=0 -> 0xFFFFF080; with uns=1 -> 0x0000F080; byte load @0x030 with uns=0 -> 0xFFFFFF80.
REQ-027 SHALL pass: req=2'b11 held continuously after reset -> grants 0,1,0,1; no port starved.
REQ-028 SHALL pass: word load @0x013 -> no dm_wr_en and no DMEM cycle; rsp_err=1 and rsp_rdata=0 next cycle.
REQ-029 SHALL pass: reset_n pulsed low during RMW_RD of a byte store -> no rsp_valid; target word unchanged after reset; ready[0] high in the first cycle after release.
